// File: rtl/id_stage.sv
// RV32I decode stage: registers one decoded instruction between fetch and execute,
// generates immediates, flags unknown opcodes and stalls on read-after-write hazards.
module id_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic                  out_wen,
  output logic                  out_mem_re,
  output logic                  out_mem_we,
  output logic                  out_illegal,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_JALR   = 7'b1100111,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic                  wen;
    logic                  mem_re;
    logic                  mem_we;
    logic                  illegal;
  } bundle_t;

  bundle_t               dec;
  bundle_t               out_q;
  logic                  out_valid_q;
  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_next;
  logic                  hazard;
  logic                  in_fire;
  logic                  out_fire;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [REG_ADDR_W-1:0] f_rs1;
    logic [REG_ADDR_W-1:0] f_rs2;
    logic [REG_ADDR_W-1:0] f_rd;
    logic [31:0]           imm32;
    // NOTE: every combinational output gets a default up front so no path
    // through the case statement leaves a value unassigned (no latches).
    dec     = '0;
    imm32   = '0;
    f_rs1   = REG_ADDR_W'(in_inst[19:15]);
    f_rs2   = REG_ADDR_W'(in_inst[24:20]);
    f_rd    = REG_ADDR_W'(in_inst[11:7]);
    dec.pc  = in_pc;
    case (in_inst[6:0])
      OP_R: begin
        dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.rd = f_rd; dec.wen = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        dec.rs1 = f_rs1; dec.rd = f_rd; dec.wen = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_LOAD: begin
        dec.rs1 = f_rs1; dec.rd = f_rd; dec.wen = 1'b1; dec.mem_re = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.mem_we = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec.rs1 = f_rs1; dec.rs2 = f_rs2;
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                   in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd = f_rd; dec.wen = 1'b1;
        imm32  = {in_inst[31:12], 12'h000};
      end
      OP_JAL: begin
        dec.rd = f_rd; dec.wen = 1'b1;
        imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    // x0 is never a real destination, so it never enters the scoreboard.
    if (dec.rd == '0) dec.wen = 1'b0;
    dec.imm = XLEN'($signed(imm32));
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and handshakes
  // ---------------------------------------------------------------------------
  function automatic logic src_hazard(input logic [REG_ADDR_W-1:0] rs);
    logic busy_sb;
    logic busy_held;
    busy_sb   = pend[rs] && !(wb_en && wb_addr == rs);
    busy_held = out_valid_q && out_q.wen && out_q.rd == rs;
    return (rs != '0) && (busy_sb || busy_held);
  endfunction

  always_comb begin
    hazard = src_hazard(dec.rs1) || src_hazard(dec.rs2);
  end

  assign in_ready = !flush && (!out_valid_q || out_ready) && !hazard;
  assign in_fire  = in_valid && in_ready;
  // A flush cancels any transfer of the held bundle in the same cycle.
  assign out_fire = out_valid_q && out_ready && !flush;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_q       <= dec;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_wen     = out_q.wen;
  assign out_mem_re  = out_q.mem_re;
  assign out_mem_we  = out_q.mem_we;
  assign out_illegal = out_q.illegal;

  // ---------------------------------------------------------------------------
  // Register scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_next = pend;
    if (wb_en && wb_addr != '0) pend_next[wb_addr] = 1'b0;
    // Applied after the clear so a same-index set in the same cycle wins.
    if (out_fire && out_q.wen) pend_next[out_q.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: the scoreboard is real control state, not a data array, so it is
    // reset; a stale pending bit after reset would deadlock decode.
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected bundles are queued at issue time and
// compared when the DUT hands a bundle to execute.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_wen;
  logic        out_mem_re;
  logic        out_mem_we;
  logic        out_illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wen;
    logic        re;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];

  id_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_wen(out_wen), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm, input logic wen,
                              input logic re, input logic we, input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    e.wen = wen; e.re = re; e.we = we; e.ill = ill;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, wait (bounded) for in_ready, queue its expectation.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    int n;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("issue_ready", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard consumer: a transfer happens at the next edge when these hold.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (flush) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pc",      out_pc,             e.pc);
          check("rs1",     32'(out_rs1),       32'(e.rs1));
          check("rs2",     32'(out_rs2),       32'(e.rs2));
          check("rd",      32'(out_rd),        32'(e.rd));
          check("imm",     out_imm,            e.imm);
          check("wen",     32'(out_wen),       32'(e.wen));
          check("mem_re",  32'(out_mem_re),    32'(e.re));
          check("mem_we",  32'(out_mem_we),    32'(e.we));
          check("illegal", 32'(out_illegal),   32'(e.ill));
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_out_imm",   out_imm,        32'd0);
    check("rst_out_rd",    32'(out_rd),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // addi x1,x0,5
    issue(32'h00500093, 32'h100, mk(32'h100, 5'd0, 5'd0, 5'd1, 32'd5, 1, 0, 0, 0));

    // add x2,x1,x1: stalled by the held writer, then by pend[1]
    in_valid = 1'b1; in_inst = 32'h00108133; in_pc = 32'h104;
    #1;
    check("raw_held_stall", 32'(in_ready), 32'd0);
    tick();
    check("raw_pend_stall", 32'(in_ready), 32'd0);
    tick();
    check("raw_pend_stall2", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd1;
    #1;
    check("wb_release", 32'(in_ready), 32'd1);
    issue(32'h00108133, 32'h104, mk(32'h104, 5'd1, 5'd1, 5'd2, 32'd0, 1, 0, 0, 0));
    wb_en = 1'b0;

    // let add transfer (pend[2] set), then retire x2
    tick();
    wb_en = 1'b1; wb_addr = 5'd2;
    tick();
    wb_en = 1'b0;

    issue(32'h00202423, 32'h108, mk(32'h108, 5'd0, 5'd2, 5'd0, 32'd8,        0, 0, 1, 0)); // sw x2,8(x0)
    issue(32'hFE000EE3, 32'h10C, mk(32'h10C, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 0, 0, 0, 0)); // beq -4
    issue(32'h008000EF, 32'h110, mk(32'h110, 5'd0, 5'd0, 5'd1, 32'd8,        1, 0, 0, 0)); // jal x1,8
    issue(32'h123452B7, 32'h114, mk(32'h114, 5'd0, 5'd0, 5'd5, 32'h12345000, 1, 0, 0, 0)); // lui x5
    issue(32'h0000007F, 32'h118, mk(32'h118, 5'd0, 5'd0, 5'd0, 32'd0,        0, 0, 0, 1)); // illegal
    issue(32'h00000013, 32'h11C, mk(32'h11C, 5'd0, 5'd0, 5'd0, 32'd0,        0, 0, 0, 0)); // nop, rd=0
    issue(32'hFFF02183, 32'h120, mk(32'h120, 5'd0, 5'd0, 5'd3, 32'hFFFFFFFF, 1, 1, 0, 0)); // lw x3,-1(x0)
    tick();

    // hold then flush: addi x6,x0,1 sits with out_ready=0
    out_ready = 1'b0;
    issue(32'h00100313, 32'h124, mk(32'h124, 5'd0, 5'd0, 5'd6, 32'd1, 1, 0, 0, 0));
    tick(); tick();
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_pc",    out_pc,         32'h124);
    check("hold_rd",    32'(out_rd),    32'd6);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h000073B7; in_pc = 32'h128;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    in_inst = 32'h00630433; // add x8,x6,x6: flushed writer never reached the scoreboard
    #1;
    check("flush_no_pend6", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_inst = 32'h00108133; in_pc = 32'h200; // x1 still pending from jal
    #1;
    check("pend1_kept", 32'(in_ready), 32'd0);

    // reset during the stall clears everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready",  32'(in_ready),  32'd1);
    issue(32'h00108133, 32'h200, mk(32'h200, 5'd1, 5'd1, 5'd2, 32'd0, 1, 0, 0, 0));

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
